hps_pixel_reader: RTL
=====================

# hps_pixel_reader

Readback engine that lets the HPS fetch single pixels from the resized-image RAM over a four-phase request/done handshake. It is the read-direction counterpart to the existing HPS pixel write path into the original-image RAM. It requests the shared RAM port from the port mux and waits out redimensioning. It then reads with fixed RAM latency and returns the byte plus an error flag to HPS-facing PIO registers. It runs in the clk_100 domain alongside both image RAMs.

## Interface
- ADDR_W, 19, RAM word address width (640×480 space)
- DATA_W, 8, pixel width
- RAM_LAT, 2, cycles from address valid to ram_q valid (registered address + registered q)
- GNT_TIMEOUT, 1024, max cycles waiting for grant before error
- clk_100  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low
- SolicitaLeitura  in  1  HPS read request, asynchronous to clk_100, level (four-phase)
- addr_in_hps  in  ADDR_W  pixel address; stable while SolicitaLeitura high
- img_size  in  ADDR_W  valid pixel count of current image (IMG_W·IMG_H)
- ram_busy  in  1  redimensioning owns the RAM port
- ram_gnt  in  1  port mux grants read access
- ram_q  in  DATA_W  RAM read data
- ram_req  out  1  request for the RAM port
- ram_addr  out  ADDR_W  read address
- dado_pixel_hps  out  DATA_W  returned pixel, held until next capture
- done_read  out  1  handshake acknowledge
- erro_leitura  out  1  last read failed (out of range or timeout); valid with done_read

## Operation
- SolicitaLeitura passes through a 2-flop synchronizer → req_s. addr_in_hps is sampled only when leaving IDLE; HPS guarantees its stability.
- FSM states: IDLE, REQ, ISSUE, CAPTURE, DONE.
- IDLE: on req_s=1, latch addr into addr_r.
  - If addr_in_hps ≥ img_size → DONE with erro_leitura=1 and dado_pixel_hps=0x00.
  - Otherwise → REQ with erro_leitura=0.
- REQ: ram_req=1, ram_addr=addr_r.
  - If ram_gnt=1 and ram_busy=0 → ISSUE, latency counter cleared.
  - Each cycle without grant increments the timeout counter. At GNT_TIMEOUT → DONE with erro_leitura=1 and dado=0x00.
- ISSUE: ram_req=1, ram_addr=addr_r held. Counter counts RAM_LAT cycles → CAPTURE.
  - If ram_busy rises or ram_gnt drops in ISSUE → return to REQ. The latency counter clears; the timeout counter is not reset.
- CAPTURE: dado_pixel_hps ← ram_q, ram_req=1 this cycle → DONE.
- DONE: done_read=1, ram_req=0. Stays until req_s=0, then → IDLE with done_read=0 the same edge.
- HPS deasserting SolicitaLeitura mid-operation does not abort. The read completes, and done_read asserts for exactly one cycle if req_s is already low on entering DONE.
- Comparison addr ≥ img_size is unsigned ADDR_W-bit. img_size=0 makes every read an error.
- Timeout counter width is clog2(GNT_TIMEOUT)+1 and saturates; no wrap.

## Timing
- Reset values: ram_req=0, ram_addr=0, dado_pixel_hps=0x00, done_read=0, erro_leitura=0, state IDLE, counters 0.
- Reset asserted mid-operation immediately drops ram_req and done_read (async clear).
- Latency, SolicitaLeitura rising to done_read with grant available:
  - 2 sync cycles
  - + 1 (IDLE→REQ)
  - + 1 (REQ→ISSUE)
  - + RAM_LAT
  - + 1 (CAPTURE)
  - = 7 cycles at RAM_LAT=2.
- Out-of-range read: done_read 3 cycles after SolicitaLeitura rising.
- done_read falls 3 cycles after SolicitaLeitura falls (2 sync + 1).
- A new request is accepted no earlier than 1 cycle after done_read falls.
- ram_addr changes only in IDLE; it is glitch-free while ram_req=1.

## Structure
- Shared package coproc_pkg holds:
  - state enum encoding (IDLE=0…DONE=4)
  - ADDR_W/DATA_W defaults
  - the 640×480 screen constants already used by the display path
- One sub-module: sync_2ff (parameterised width, async active-low reset). It is reused later for other HPS PIO inputs.
- Top-level port mux arbitration stays outside this block; this block only requests.

## Test plan
- Nominal read: img_size=19200, RAM[100]=0xA5, no busy; pulse request with addr=100 → done_read 7 cycles later, dado=0xA5, erro=0, done clears 3 cycles after request falls.
- Out-of-range: img_size=19200, addr=19200 → done_read after 3 cycles, erro=1, dado=0x00, ram_req never asserts.
- Busy wait: ram_busy=1 for 50 cycles, RAM[0]=0x3C → ram_req high throughout, done_read 50 cycles later than nominal, dado=0x3C.
- Timeout: GNT_TIMEOUT=16, ram_gnt=0 forever → done_read with erro=1 after 16 REQ cycles; next read with grant returns erro=0.
- Grant lost in ISSUE: drop ram_gnt for 3 cycles one cycle into ISSUE → state returns to REQ, final dado matches RAM, no early done.
- Reset mid-op: assert reset during ISSUE → all outputs 0 asynchronously; after release, new read at addr=5 (RAM=0x11) completes normally.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: reader FSM encoding, default widths and
// the 640x480 screen geometry used by the display path.
package coproc_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int ADDR_W_DEF = $clog2(SCREEN_W * SCREEN_H);
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } rd_state_t;

endpackage

// File: rtl/hps_pixel_reader_if.sv
// RAM-port request bundle between the pixel reader (master) and the port mux /
// resized-image RAM (slave).
interface hps_pixel_reader_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              ram_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_busy;
  logic              ram_gnt;
  logic [DATA_W-1:0] ram_q;

  modport master (output ram_req, ram_addr, input ram_busy, ram_gnt, ram_q);
  modport slave  (input ram_req, ram_addr, output ram_busy, ram_gnt, ram_q);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow HPS PIO levels entering the clk_100 domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_100,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hps_pixel_reader.sv
// HPS single-pixel readback from the resized-image RAM over a four-phase
// SolicitaLeitura/done_read handshake, with range check and grant timeout.
module hps_pixel_reader
  import coproc_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RAM_LAT     = 2,
  parameter int GNT_TIMEOUT = 1024
) (
  input  logic               clk_100,
  input  logic               reset,
  input  logic               SolicitaLeitura,
  input  logic [ADDR_W-1:0]  addr_in_hps,
  input  logic [ADDR_W-1:0]  img_size,
  hps_pixel_reader_if.master ram,
  output logic [DATA_W-1:0]  dado_pixel_hps,
  output logic               done_read,
  output logic               erro_leitura
);

  localparam int TW = $clog2(GNT_TIMEOUT) + 1;
  localparam int LW = $clog2(RAM_LAT) + 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(GNT_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_SAT   = TW'(GNT_TIMEOUT);
  localparam logic [LW-1:0] LAT_LAST = LW'(RAM_LAT - 1);

  rd_state_t         state, state_nxt;
  logic              req_s;
  logic              grant_ok;
  logic [ADDR_W-1:0] addr_r, addr_nxt;
  logic [DATA_W-1:0] dado_nxt;
  logic              erro_nxt;
  logic [TW-1:0]     to_cnt, to_nxt;
  logic [LW-1:0]     lat_cnt, lat_nxt;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk_100 (clk_100),
    .reset   (reset),
    .d       (SolicitaLeitura),
    .q       (req_s)
  );

  assign grant_ok = ram.ram_gnt & ~ram.ram_busy;

  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      addr_r         <= '0;
      dado_pixel_hps <= '0;
      erro_leitura   <= 1'b0;
      to_cnt         <= '0;
      lat_cnt        <= '0;
    end else begin
      state          <= state_nxt;
      addr_r         <= addr_nxt;
      dado_pixel_hps <= dado_nxt;
      erro_leitura   <= erro_nxt;
      to_cnt         <= to_nxt;
      lat_cnt        <= lat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_r;
    dado_nxt  = dado_pixel_hps;
    erro_nxt  = erro_leitura;
    to_nxt    = to_cnt;
    lat_nxt   = lat_cnt;
    unique case (state)
      IDLE: begin
        to_nxt  = '0;
        lat_nxt = '0;
        if (req_s) begin
          addr_nxt = addr_in_hps;
          if (addr_in_hps >= img_size) begin
            state_nxt = DONE;
            erro_nxt  = 1'b1;
            dado_nxt  = '0;
          end else begin
            state_nxt = REQ;
            erro_nxt  = 1'b0;
          end
        end
      end
      REQ: begin
        if (grant_ok) begin
          state_nxt = ISSUE;
          lat_nxt   = '0;
        end else if (to_cnt >= TO_LAST) begin
          state_nxt = DONE;
          erro_nxt  = 1'b1;
          dado_nxt  = '0;
          to_nxt    = TO_SAT;
        end else begin
          to_nxt = to_cnt + TW'(1);
        end
      end
      // Losing the port mid-read restarts the latency count but keeps the
      // accumulated grant wait, so repeated preemption still times out.
      ISSUE: begin
        if (!grant_ok) begin
          state_nxt = REQ;
          lat_nxt   = '0;
        end else if (lat_cnt == LAT_LAST) begin
          state_nxt = CAPTURE;
        end else begin
          lat_nxt = lat_cnt + LW'(1);
        end
      end
      CAPTURE: begin
        dado_nxt  = ram.ram_q;
        state_nxt = DONE;
      end
      DONE: begin
        if (!req_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ram.ram_req  = (state == REQ) || (state == ISSUE) || (state == CAPTURE);
  assign ram.ram_addr = addr_r;
  assign done_read    = (state == DONE);

endmodule
